// File: rtl/uart_rx_fifo_if.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Purpose  : Signal bundle between a UART receiver/bus master and the
//            receive FIFO.
// Ports    : wr_tick/wr_data - character strobe and value from the receiver
//            rd              - pop request, one entry per asserted cycle
//            overrun_clr     - clears the sticky overrun flag
//            rd_data         - head entry (first-word-fall-through)
//            empty/full/count/overrun - FIFO status
//            master modport: drives writes/pops; slave modport: the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
);
  logic                 wr_tick;
  logic [DATA_BITS-1:0] wr_data;
  logic                 rd;
  logic                 overrun_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 empty;
  logic                 full;
  logic [ADDR_BITS:0]   count;
  logic                 overrun;

  modport master (
    output wr_tick, wr_data, rd, overrun_clr,
    input  rd_data, empty, full, count, overrun
  );

  modport slave (
    input  wr_tick, wr_data, rd, overrun_clr,
    output rd_data, empty, full, count, overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Circular receive buffer downstream of a UART receiver. Captures
//            a character on each wr_tick, presents the oldest entry on
//            rd_data (FWFT) and pops on rd. Reports empty/full/count and a
//            sticky overrun flag for characters dropped while full.
// Ports    : clk   - clock
//            reset - asynchronous, active-high reset
//            bus   - uart_rx_fifo_if slave modport (write, pop, status)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  uart_rx_fifo_if.slave       bus
);

  localparam int                 c_DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] c_COUNT_MAX = (ADDR_BITS + 1)'(c_DEPTH);
  localparam logic [ADDR_BITS:0] c_COUNT_ONE = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] c_PTR_ONE = ADDR_BITS'(1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [DATA_BITS-1:0]   r_mem [c_DEPTH];
  logic [ADDR_BITS-1:0]   r_wrPtr;
  logic [ADDR_BITS-1:0]   r_rdPtr;
  logic [ADDR_BITS:0]     r_count;
  logic [ADDR_BITS:0]     w_countNext;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_overrun;
  logic                   w_doWrite;
  logic                   w_doRead;
  logic                   w_drop;

  // Next-state / datapath control.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_doRead    = bus.rd && !r_empty;
    // When full, a simultaneous pop frees the head slot, so the write fits.
    w_doWrite   = bus.wr_tick && (!r_full || bus.rd);
    w_drop      = bus.wr_tick && r_full && !bus.rd;

    case ({w_doWrite, w_doRead})
      2'b10:   w_countNext = r_count + c_COUNT_ONE;
      2'b01:   w_countNext = r_count - c_COUNT_ONE;
      default: w_countNext = r_count;
    endcase

    case (r_state)
      S_EMPTY: begin
        if (w_doWrite) begin
          w_stateNext = (c_COUNT_ONE == c_COUNT_MAX) ? S_FULL : S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        if (w_doWrite && !w_doRead && r_count == c_COUNT_MAX - c_COUNT_ONE) begin
          w_stateNext = S_FULL;
        end else if (w_doRead && !w_doWrite && r_count == c_COUNT_ONE) begin
          w_stateNext = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_doRead && !w_doWrite) begin
          w_stateNext = (c_COUNT_MAX == c_COUNT_ONE) ? S_EMPTY : S_PARTIAL;
        end
      end
      default: w_stateNext = S_EMPTY;
    endcase
  end

  // Control registers. empty/full are decoded from the next state so the
  // status outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_EMPTY;
      r_count   <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
      r_empty <= (w_stateNext == S_EMPTY);
      r_full  <= (w_stateNext == S_FULL);
      if (w_doWrite) r_wrPtr <= r_wrPtr + c_PTR_ONE;
      if (w_doRead)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
      // A drop in the same cycle as a clear must leave the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      r_mem[r_wrPtr] <= bus.wr_data;
    end
  end

  assign bus.rd_data = r_mem[r_rdPtr];
  assign bus.empty   = r_empty;
  assign bus.full    = r_full;
  assign bus.count   = r_count;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo. A queue-based reference
//            model tracks contents and overrun; expected pops go into a
//            scoreboard queue checked by an independent monitor.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

  uart_rx_fifo #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mQ[$];    // reference FIFO contents, oldest first
  logic [DW-1:0] expQ[$];  // scoreboard of expected popped characters
  bit            mOvr;
  int            nChecks = 0;
  int            nErr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the inputs held across one active edge.
  task automatic model_edge();
    int sz;
    bit doRd;
    bit doWr;
    if (reset) begin
      mQ.delete();
      mOvr = 1'b0;
      return;
    end
    sz   = mQ.size();
    doRd = bus.rd && (sz > 0);
    doWr = bus.wr_tick && ((sz < DEPTH) || bus.rd);
    if (doRd) void'(mQ.pop_front());
    if (doWr) mQ.push_back(bus.wr_data);
    if (bus.wr_tick && !doWr) mOvr = 1'b1;
    else if (bus.overrun_clr) mOvr = 1'b0;
  endtask

  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rdv, input bit clr);
    @(posedge clk);
    model_edge();
    #1;
    bus.wr_tick     = wr;
    bus.wr_data     = d;
    bus.rd          = rdv;
    bus.overrun_clr = clr;
    if (rdv && mQ.size() > 0) expQ.push_back(mQ[0]);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    model_edge();
    #1;
    bus.wr_tick     = 1'b0;
    bus.wr_data     = '0;
    bus.rd          = 1'b0;
    bus.overrun_clr = 1'b0;
    reset           = 1'b1;
    mQ.delete();
    expQ.delete();
    mOvr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: status every cycle, scoreboard on each accepted pop.
  always @(negedge clk) begin
    if (!reset) begin
      chk("count",   32'(bus.count),   32'(mQ.size()));
      chk("empty",   32'(bus.empty),   32'(mQ.size() == 0));
      chk("full",    32'(bus.full),    32'(mQ.size() == DEPTH));
      chk("overrun", 32'(bus.overrun), 32'(mOvr));
      if (mQ.size() > 0) chk("head", 32'(bus.rd_data), 32'(mQ[0]));
      if (bus.rd && !bus.empty) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nErr++;
          $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", bus.rd_data, $time);
        end else begin
          chk("pop", 32'(bus.rd_data), 32'(expQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wrP;
    int rdP;
    reset           = 1'b1;
    bus.wr_tick     = 1'b0;
    bus.wr_data     = '0;
    bus.rd          = 1'b0;
    bus.overrun_clr = 1'b0;
    mOvr            = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset.
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_count", 32'(bus.count), 32'd0);

    // Three characters in order.
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Fill, then overflow with 0x55.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t3_count",   32'(bus.count),   32'd16);
    chk("t3_full",    32'(bus.full),    32'd1);
    chk("t3_overrun", 32'(bus.overrun), 32'd1);

    // At full: clear flag, then simultaneous write 0xAA + pop.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t4_count",   32'(bus.count),   32'd16);
    chk("t4_overrun", 32'(bus.overrun), 32'd0);
    repeat (DEPTH) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t4_empty", 32'(bus.empty), 32'd1);

    // Pointer wrap with write/pop pairs.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);

    // Mid-operation reset, then 1-cycle write latency.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t6_count_pre", 32'(bus.count), 32'd5);
    pulse_reset();
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t6_rd_data", 32'(bus.rd_data), 32'h7E);

    // Clear and drop in the same cycle: set wins.
    for (int i = 1; i < DEPTH; i++) step(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t6_set_wins", 32'(bus.overrun), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("t6_cleared", 32'(bus.overrun), 32'd0);

    // Randomized traffic biased towards filling, balanced, then draining.
    for (int ph = 0; ph < 3; ph++) begin
      wrP = 70 - 20 * ph;
      rdP = 30 + 20 * ph;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          pulse_reset();
        end else begin
          step($urandom_range(0, 99) < wrP, DW'($urandom()),
               $urandom_range(0, 99) < rdP, $urandom_range(0, 99) < 5);
        end
      end
    end

    // Drain and confirm every expected pop was observed.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("final_empty", 32'(bus.empty), 32'd1);
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end

endmodule
`default_nettype wire
